video_sink: RTL

VIDEO_SINK -- requirements
Module: video_sink

---
 rtl/video_sink_if.sv | 26 ++
 rtl/video_sink.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/video_sink_if.sv
// Avalon-ST video input stream shared by the sink and whatever sources it.
interface video_sink_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] din_data;
    logic                  din_valid;
    logic                  din_ready;
    logic                  din_startofpacket;
    logic                  din_endofpacket;

    modport master (
        output din_data,
        output din_valid,
        output din_startofpacket,
        output din_endofpacket,
        input  din_ready
    );

    modport slave (
        input  din_data,
        input  din_valid,
        input  din_startofpacket,
        input  din_endofpacket,
        output din_ready
    );
endinterface

// File: rtl/video_sink.sv
// Avalon-ST video sink: decodes control packets for geometry reporting and
// splits one field of video into two ping-pong line buffers.
module video_sink #(
    parameter int DATA_WIDTH  = 8,
    parameter int WIDTH       = 720,
    parameter int HALF_HEIGHT = 288
) (
    input  logic                  clock,
    input  logic                  reset,
    video_sink_if.slave           st,
    output logic                  wr_req0,
    output logic                  wr_req1,
    output logic [DATA_WIDTH-1:0] wr_data0,
    output logic [DATA_WIDTH-1:0] wr_data1,
    input  logic                  full0,
    input  logic                  full1,
    output logic [15:0]           ctrl_width,
    output logic [15:0]           ctrl_height,
    output logic [3:0]            ctrl_interlace,
    output logic                  line_done,
    output logic                  field_done,
    output logic                  size_err,
    output logic                  pkt_err
);
    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int LW = (HALF_HEIGHT > 1) ? $clog2(HALF_HEIGHT) : 1;
    localparam logic [PW-1:0] LAST_PIX   = PW'(WIDTH - 1);
    localparam logic [LW-1:0] LAST_LINE  = LW'(HALF_HEIGHT - 1);
    localparam logic [15:0]   EXP_WIDTH  = 16'(WIDTH);
    localparam logic [15:0]   EXP_HEIGHT = 16'(HALF_HEIGHT);

    typedef enum logic [1:0] {IDLE, CTRL, VIDEO, SKIP} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pixel_q, pixel_d;
    logic [LW-1:0] line_q, line_d;
    logic          curBuf_q, curBuf_d;
    logic [3:0]    beat_q, beat_d;
    logic [15:0]   widthShift_q, widthShift_d;
    logic [15:0]   heightShift_q, heightShift_d;
    logic [15:0]   ctrlWidth_q, ctrlWidth_d;
    logic [15:0]   ctrlHeight_q, ctrlHeight_d;
    logic [3:0]    ctrlInterlace_q, ctrlInterlace_d;
    logic          sizeErr_q, sizeErr_d;
    logic          lineDone_q, lineDone_d;
    logic          fieldDone_q, fieldDone_d;
    logic          pktErr_q, pktErr_d;

    logic          readyInt;
    logic          accept;
    logic          sop;
    logic          eop;
    logic          restart;
    logic          lastPix;
    logic          lastLine;
    logic [3:0]    nibble;

    assign sop      = st.din_startofpacket;
    assign eop      = st.din_endofpacket;
    assign nibble   = st.din_data[3:0];
    assign accept   = st.din_valid && readyInt;
    // An SOP anywhere except SKIP abandons the current packet and is decoded as a new header
    assign restart  = accept && sop && (state_q != SKIP);
    assign lastPix  = (pixel_q == LAST_PIX);
    assign lastLine = (line_q == LAST_LINE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            if (eop) begin
                state_d = IDLE;
            end else if (nibble == 4'hF) begin
                state_d = CTRL;
            end else if (nibble == 4'h0) begin
                state_d = VIDEO;
            end else begin
                state_d = SKIP;
            end
        end else if (accept) begin
            case (state_q)
                CTRL:    if (eop) state_d = IDLE;
                VIDEO: begin
                    if (eop) begin
                        state_d = IDLE;
                    end else if (lastPix && lastLine) begin
                        state_d = SKIP;
                    end
                end
                SKIP:    if (eop) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Write strobes avoid reading readyInt back so the comb path stays acyclic
    always_comb begin
        readyInt = 1'b1;
        wr_req0  = 1'b0;
        wr_req1  = 1'b0;
        if (state_q == VIDEO) begin
            readyInt = curBuf_q ? !full1 : !full0;
            if (st.din_valid && !sop) begin
                wr_req0 = !curBuf_q && !full0;
                wr_req1 = curBuf_q && !full1;
            end
        end
    end

    always_comb begin
        pixel_d         = pixel_q;
        line_d          = line_q;
        curBuf_d        = curBuf_q;
        beat_d          = beat_q;
        widthShift_d    = widthShift_q;
        heightShift_d   = heightShift_q;
        ctrlWidth_d     = ctrlWidth_q;
        ctrlHeight_d    = ctrlHeight_q;
        ctrlInterlace_d = ctrlInterlace_q;
        sizeErr_d       = sizeErr_q;
        lineDone_d      = 1'b0;
        fieldDone_d     = 1'b0;
        pktErr_d        = 1'b0;
        if (restart) begin
            pixel_d  = '0;
            line_d   = '0;
            curBuf_d = 1'b0;
            beat_d   = '0;
            if ((state_q == VIDEO) || (eop && nibble == 4'h0)) begin
                pktErr_d = 1'b1;
            end
        end else if (accept && state_q == CTRL) begin
            if (beat_q < 4'd9) begin
                beat_d = beat_q + 4'd1;
                if (beat_q < 4'd4) begin
                    widthShift_d = {widthShift_q[11:0], nibble};
                end else if (beat_q < 4'd8) begin
                    heightShift_d = {heightShift_q[11:0], nibble};
                end else begin
                    ctrlWidth_d     = widthShift_q;
                    ctrlHeight_d    = heightShift_q;
                    ctrlInterlace_d = nibble;
                    sizeErr_d       = (widthShift_q != EXP_WIDTH) || (heightShift_q != EXP_HEIGHT);
                end
            end
        end else if (accept && state_q == VIDEO) begin
            if (lastPix) begin
                pixel_d    = '0;
                line_d     = line_q + LW'(1);
                curBuf_d   = !curBuf_q;
                lineDone_d = 1'b1;
                if (lastLine) begin
                    line_d      = '0;
                    fieldDone_d = 1'b1;
                    pktErr_d    = !eop;
                end else begin
                    pktErr_d = eop;
                end
            end else begin
                pixel_d  = pixel_q + PW'(1);
                pktErr_d = eop;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixel_q         <= '0;
            line_q          <= '0;
            curBuf_q        <= 1'b0;
            beat_q          <= '0;
            widthShift_q    <= '0;
            heightShift_q   <= '0;
            ctrlWidth_q     <= '0;
            ctrlHeight_q    <= '0;
            ctrlInterlace_q <= '0;
            sizeErr_q       <= 1'b0;
            lineDone_q      <= 1'b0;
            fieldDone_q     <= 1'b0;
            pktErr_q        <= 1'b0;
        end else begin
            pixel_q         <= pixel_d;
            line_q          <= line_d;
            curBuf_q        <= curBuf_d;
            beat_q          <= beat_d;
            widthShift_q    <= widthShift_d;
            heightShift_q   <= heightShift_d;
            ctrlWidth_q     <= ctrlWidth_d;
            ctrlHeight_q    <= ctrlHeight_d;
            ctrlInterlace_q <= ctrlInterlace_d;
            sizeErr_q       <= sizeErr_d;
            lineDone_q      <= lineDone_d;
            fieldDone_q     <= fieldDone_d;
            pktErr_q        <= pktErr_d;
        end
    end

    assign st.din_ready    = readyInt;
    assign wr_data0       = st.din_data;
    assign wr_data1       = st.din_data;
    assign ctrl_width     = ctrlWidth_q;
    assign ctrl_height    = ctrlHeight_q;
    assign ctrl_interlace = ctrlInterlace_q;
    assign size_err       = sizeErr_q;
    assign line_done      = lineDone_q;
    assign field_done     = fieldDone_q;
    assign pkt_err        = pktErr_q;
endmodule
